// File: rtl/lsu_pkg.sv
// lsu shared types: funct3 encodings, FSM states, latched request bundle.
// Imported by every lsu file.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_req_t;

endpackage

// File: rtl/lsu_if.sv
// lsu request, memory bus and response signals.
// slave = the lsu; master = core plus memory around it.
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_fault;

  modport slave (
    input  req_valid, req_store, req_funct3,
    input  req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata,
    output resp_valid, resp_data, resp_rd, resp_fault,
    input  resp_ready
  );

  modport master (
    output req_valid, req_store, req_funct3,
    output req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata,
    input  resp_valid, resp_data, resp_rd, resp_fault,
    output resp_ready
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering, load extension and access fault decode.
// Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        fault,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        bad_f3;
  logic        mis;
  logic [31:0] sh;

  assign is_b = funct3[1:0] == 2'b00;
  assign is_h = funct3[1:0] == 2'b01;
  assign is_w = funct3[1:0] == 2'b10;

  assign bad_f3 = store
    ? (funct3[2] | (funct3[1:0] == 2'b11))
    : ((funct3 == 3'b011) | (funct3[2] & funct3[1]));
  assign mis   = (is_h & off[0]) | (is_w & (off != 2'b00));
  assign fault = bad_f3 | mis;

  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    wstrb      = 4'b0000;
    lane_wdata = 32'h0;
    if (store) begin
      unique case (1'b1)
        is_b: begin
          wstrb      = 4'b0001 << off;
          lane_wdata = {4{wdata[7:0]}};
        end
        is_h: begin
          wstrb      = 4'b0011 << off;
          lane_wdata = {2{wdata[15:0]}};
        end
        default: begin
          wstrb      = 4'b1111;
          lane_wdata = wdata;
        end
      endcase
    end
  end

  always_comb begin
    load_data = sh;
    unique case (1'b1)
      funct3 == F3_B:  load_data = {{24{sh[7]}}, sh[7:0]};
      funct3 == F3_BU: load_data = {24'h0, sh[7:0]};
      funct3 == F3_H:  load_data = {{16{sh[15]}}, sh[15:0]};
      funct3 == F3_HU: load_data = {16'h0, sh[15:0]};
      default:         load_data = sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding access, IDLE/BUS/RESP FSM.
// Outputs come only from the latched request, state and resp registers.
module lsu
  import lsu_pkg::*;
(
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);

  state_t      state;
  state_t      nxt;
  lsu_req_t    r;
  logic        idle;
  logic        in_bus;
  logic        acc;
  logic        fault;
  logic        a_store;
  logic [2:0]  a_f3;
  logic [1:0]  a_off;
  logic [3:0]  strb;
  logic [31:0] lane_wd;
  logic [31:0] ld;
  logic [31:0] data_q;
  logic [4:0]  rd_q;
  logic        flt_q;

  assign idle   = state == IDLE;
  assign in_bus = state == BUS;
  assign acc    = idle && bus.req_valid;

  // Fault is judged on the live request; lanes and extraction on the latched one.
  assign a_store = idle ? bus.req_store      : r.store;
  assign a_f3    = idle ? bus.req_funct3     : r.funct3;
  assign a_off   = idle ? bus.req_addr[1:0]  : r.addr[1:0];

  lsu_align u_align (
    .store      (a_store),
    .funct3     (a_f3),
    .off        (a_off),
    .wdata      (r.wdata),
    .rdata      (bus.mem_rdata),
    .fault      (fault),
    .wstrb      (strb),
    .lane_wdata (lane_wd),
    .load_data  (ld)
  );

  assign bus.req_ready  = idle;
  assign bus.mem_valid  = in_bus;
  assign bus.mem_addr   = {r.addr[31:2], 2'b00};
  assign bus.mem_wstrb  = in_bus ? strb : 4'b0000;
  assign bus.mem_wdata  = in_bus ? lane_wd : 32'h0;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_data  = data_q;
  assign bus.resp_rd    = rd_q;
  assign bus.resp_fault = flt_q;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (acc) nxt = fault ? RESP : BUS;
      BUS:  if (bus.mem_ready) nxt = RESP;
      RESP: if (bus.resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r      <= '0;
      data_q <= 32'h0;
      rd_q   <= 5'd0;
      flt_q  <= 1'b0;
    end else if (acc) begin
      r <= '{
        store:  bus.req_store,
        funct3: bus.req_funct3,
        addr:   bus.req_addr,
        wdata:  bus.req_wdata,
        rd:     bus.req_rd
      };
      data_q <= 32'h0;
      rd_q   <= 5'd0;
      flt_q  <= fault;
    end else if (in_bus && bus.mem_ready) begin
      data_q <= r.store ? 32'h0 : ld;
      rd_q   <= r.store ? 5'd0 : r.rd;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// lsu bench: directed plus random accesses, responses checked
// against a scoreboard queue filled when each request is driven.
module tb_lsu;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];

  lsu_if u_if ();

  lsu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour written byte by byte.
  task automatic model(input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdata, output logic flt,
                       output logic [3:0] strb, output logic [31:0] mwd,
                       output logic [31:0] ldv);
    int sz;
    int off;
    logic ill;
    off = int'(addr[1:0]);
    sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (st) ill = (f3 != 3'b000) && (f3 != 3'b001) && (f3 != 3'b010);
    else    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    flt  = ill || (off % sz != 0);
    strb = 4'b0000;
    mwd  = 32'h0;
    ldv  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (st && i >= off && i < off + sz) strb[i] = 1'b1;
      mwd[i*8 +: 8] = wd[(i % sz)*8 +: 8];
    end
    for (int i = 0; i < 4; i++) begin
      if (i < sz) ldv[i*8 +: 8] = rdata[((off + i) % 4)*8 +: 8];
      else if (!f3[2]) ldv[i*8 +: 8] = {8{ldv[sz*8-1]}};
    end
    if (flt || st) ldv = 32'h0;
  endtask

  task automatic txn(input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [4:0] rd, input logic [31:0] rdata,
                     input int mw, input int rw, input logic xf,
                     input logic [3:0] xs, input logic [31:0] xwd,
                     input logic [31:0] xd);
    exp_t e;
    chk("idle_req_ready", 32'(u_if.req_ready), 32'd1);
    u_if.req_valid  = 1'b1;
    u_if.req_store  = st;
    u_if.req_funct3 = f3;
    u_if.req_addr   = addr;
    u_if.req_wdata  = wd;
    u_if.req_rd     = rd;
    sbq.push_back('{data: xd, rd: (st || xf) ? 5'd0 : rd, fault: xf});
    @(negedge clk);
    u_if.req_valid = 1'b0;
    u_if.req_addr  = 32'hFFFF_FFFF;
    u_if.req_wdata = 32'h5555_5555;
    if (xf) begin
      chk("flt_mem_valid", 32'(u_if.mem_valid), 32'd0);
    end else begin
      for (int k = 0; k <= mw; k++) begin
        chk("bus_mem_valid", 32'(u_if.mem_valid), 32'd1);
        chk("bus_req_ready", 32'(u_if.req_ready), 32'd0);
        chk("bus_resp_valid", 32'(u_if.resp_valid), 32'd0);
        chk("mem_addr", u_if.mem_addr, {addr[31:2], 2'b00});
        chk("mem_wstrb", 32'(u_if.mem_wstrb), 32'(xs));
        if (st) chk("mem_wdata", u_if.mem_wdata, xwd);
        u_if.mem_ready = (k == mw);
        u_if.mem_rdata = (k == mw) ? rdata : ~rdata;
        @(negedge clk);
      end
      u_if.mem_ready = 1'b0;
      u_if.mem_rdata = 32'h0;
    end
    for (int k = 0; k <= rw; k++) begin
      chk("resp_valid", 32'(u_if.resp_valid), 32'd1);
      chk("resp_req_ready", 32'(u_if.req_ready), 32'd0);
      chk("resp_mem_valid", 32'(u_if.mem_valid), 32'd0);
      if (sbq.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sbq[0];
        chk("resp_data", u_if.resp_data, e.data);
        chk("resp_rd", 32'(u_if.resp_rd), 32'(e.rd));
        chk("resp_fault", 32'(u_if.resp_fault), 32'(e.fault));
      end
      u_if.resp_ready = (k == rw);
      @(negedge clk);
    end
    if (sbq.size() != 0) void'(sbq.pop_front());
    u_if.resp_ready = 1'b0;
    chk("post_resp_valid", 32'(u_if.resp_valid), 32'd0);
    chk("post_req_ready", 32'(u_if.req_ready), 32'd1);
  endtask

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        flt;
    logic [3:0]  strb;
    logic [31:0] mwd;
    logic [31:0] ldv;

    u_if.req_valid  = 1'b0;
    u_if.req_store  = 1'b0;
    u_if.req_funct3 = 3'b000;
    u_if.req_addr   = 32'h0;
    u_if.req_wdata  = 32'h0;
    u_if.req_rd     = 5'd0;
    u_if.mem_ready  = 1'b0;
    u_if.mem_rdata  = 32'h0;
    u_if.resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(u_if.req_ready), 32'd1);
    chk("rst_mem_valid", 32'(u_if.mem_valid), 32'd0);
    chk("rst_mem_wstrb", 32'(u_if.mem_wstrb), 32'd0);
    chk("rst_mem_addr", u_if.mem_addr, 32'h0);
    chk("rst_mem_wdata", u_if.mem_wdata, 32'h0);
    chk("rst_resp_valid", 32'(u_if.resp_valid), 32'd0);
    chk("rst_resp_data", u_if.resp_data, 32'h0);
    chk("rst_resp_rd", 32'(u_if.resp_rd), 32'd0);
    chk("rst_resp_fault", 32'(u_if.resp_fault), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    txn(0, 3'b000, 32'h1003, 32'h0, 5'd7, 32'h80FF_1234,
        0, 0, 0, 4'b0000, 32'h0, 32'hFFFF_FF80);
    txn(1, 3'b001, 32'h2002, 32'hDEAD_BEEF, 5'd9, 32'h0,
        0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    txn(0, 3'b010, 32'h3001, 32'h0, 5'd3, 32'h0,
        0, 0, 1, 4'b0000, 32'h0, 32'h0);
    txn(1, 3'b100, 32'h0010, 32'h1234_5678, 5'd4, 32'h0,
        0, 0, 1, 4'b0000, 32'h0, 32'h0);
    txn(0, 3'b101, 32'h4002, 32'h0, 5'd12, 32'hABCD_0000,
        3, 0, 0, 4'b0000, 32'h0, 32'h0000_ABCD);
    txn(0, 3'b001, 32'h5000, 32'h0, 5'd31, 32'h1234_8001,
        0, 4, 0, 4'b0000, 32'h0, 32'hFFFF_8001);
    txn(1, 3'b010, 32'h6000, 32'h1122_3344, 5'd1, 32'h0,
        0, 0, 0, 4'b1111, 32'h1122_3344, 32'h0);
    txn(0, 3'b100, 32'h6001, 32'h0, 5'd2, 32'h1122_3344,
        0, 0, 0, 4'b0000, 32'h0, 32'h0000_0033);
    txn(1, 3'b000, 32'h6003, 32'h0000_00A5, 5'd2, 32'h0,
        1, 1, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0);

    // Reset while the bus cycle is pending.
    u_if.req_valid  = 1'b1;
    u_if.req_store  = 1'b0;
    u_if.req_funct3 = 3'b010;
    u_if.req_addr   = 32'h7000;
    u_if.req_rd     = 5'd5;
    @(negedge clk);
    u_if.req_valid = 1'b0;
    chk("pre_rst_mem_valid", 32'(u_if.mem_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_mem_valid", 32'(u_if.mem_valid), 32'd0);
    chk("async_resp_valid", 32'(u_if.resp_valid), 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("after_rst_resp", 32'(u_if.resp_valid), 32'd0);
    chk("after_rst_mem", 32'(u_if.mem_valid), 32'd0);
    txn(0, 3'b010, 32'h7000, 32'h0, 5'd5, 32'hCAFE_F00D,
        0, 0, 0, 4'b0000, 32'h0, 32'hCAFE_F00D);

    for (int n = 0; n < 40; n++) begin
      st    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = $urandom;
      wd    = $urandom;
      rdata = $urandom;
      model(st, f3, addr, wd, rdata, flt, strb, mwd, ldv);
      txn(st, f3, addr, wd, 5'($urandom_range(0, 31)), rdata,
          $urandom_range(0, 2), $urandom_range(0, 2),
          flt, strb, mwd, ldv);
    end

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core; sits directly downstream of the ALU in the execute stage. Accepts one memory request per transaction: the ALU result as effective address, rs2 as store data, funct3 as access size and sign. Drives a single-outstanding valid/ready memory bus, steers byte lanes, sign- or zero-extends load data, and returns a writeback response or a misalignment/illegal-size fault.

## Interface
- No parameters; address and data are fixed at 32 bits.
- `clk` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept.
- `req_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr` in 32: effective address (ALU add result).
- `req_wdata` in 32: store data (rs2); ignored for loads.
- `req_rd` in 5: destination register; ignored for stores.
- `mem_valid` out 1: bus request active.
- `mem_ready` in 1: bus completes transfer this cycle.
- `mem_addr` out 32: `{req_addr[31:2], 2'b00}`.
- `mem_wstrb` out 4: byte enables; 0000 for loads.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read data, valid when `mem_valid && mem_ready` on a load.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes response.
- `resp_data` out 32: extended load data; 0 for stores and faults.
- `resp_rd` out 5: latched rd for loads; 0 for stores and faults.
- `resp_fault` out 1: misaligned or illegal-size access.

## Operation
- FSM states: IDLE, BUS, RESP. Reset state IDLE.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, latch all req fields. If the access is faulting, go to RESP with fault=1 and no bus cycle; otherwise go to BUS.
- Fault conditions: H/HU with `addr[0]`=1; W with `addr[1:0]`≠00; load funct3 ∈ {011,110,111}; store funct3 ∉ {000,001,010}.
- BUS: `mem_valid`=1, with `mem_addr`, `mem_wstrb` and `mem_wdata` held stable from latched values until `mem_ready`. On `mem_ready`, capture extracted load data and go to RESP.
- RESP: `resp_valid`=1, and all resp fields are stable until `resp_ready`; then go to IDLE. Stores also produce a response (data 0, rd 0, fault 0).
- Store lanes, with off = `addr[1:0]`:
  - B: wdata `{4{wdata[7:0]}}`, wstrb `0001<<off`.
  - H: wdata `{2{wdata[15:0]}}`, wstrb `0011<<off`.
  - W: wdata unchanged, wstrb 1111.
- Load extraction: `sh = mem_rdata >> (8*off)`.
  - B: sign-extend `sh[7:0]`.
  - BU: zero-extend `sh[7:0]`.
  - H: sign-extend `sh[15:0]`.
  - HU: zero-extend `sh[15:0]`.
  - W: `sh` unchanged.
- Only one transaction is in flight; `req_ready`=0 in BUS and RESP. There is no IDLE bypass: a response and a new accept never occur in the same cycle.

## Timing
- Reset values: `req_ready`=1, `mem_valid`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0, `resp_valid`=0, `resp_data`=0, `resp_rd`=0, `resp_fault`=0.
- Cycle 0: request accepted. Cycle 1: `mem_valid` high. If `mem_ready` is high in cycle 1, `resp_valid` goes high in cycle 2.
- Minimum accept-to-response latency is 2 cycles for bus accesses and 1 cycle for faults.
- Bus wait states: stay in BUS indefinitely while `mem_ready`=0.
- `mem_ready` is ignored when `mem_valid`=0.
- Response backpressure: stay in RESP indefinitely while `resp_ready`=0.
- Reset asserted in any state returns the FSM to IDLE and drops `mem_valid` and `resp_valid` asynchronously. The in-flight transaction is discarded and no response is produced.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*`, `mem_ready` or `resp_ready` to any output.

## Structure
- `lsu_pkg` holds:
  - the funct3 size/sign encodings as named constants;
  - the FSM state enum;
  - a `lsu_req_t` struct bundling store, funct3, addr, wdata and rd.
- Sub-module `lsu_align`: purely combinational. It computes fault, wstrb and replicated wdata from (store, funct3, off, wdata), and computes extracted load data from (funct3, off, rdata). It is instantiated once; the FSM and registers stay in `lsu`.

## Test plan
- LB at addr 0x1003, rdata 0x80FF_1234 -> `mem_addr` 0x1000, wstrb 0000, `resp_data` 0xFFFF_FF80, `resp_rd` = req_rd, fault 0.
- SH at addr 0x2002, wdata 0xDEAD_BEEF -> wdata 0xBEEF_BEEF, wstrb 1100, response with data 0, rd 0.
- LW at addr 0x3001 -> no `mem_valid` ever, `resp_valid` in cycle 1, fault 1, data 0. Same for store funct3 100.
- LHU at 0x4002, rdata 0xABCD_0000, `mem_ready` held low 3 cycles -> `mem_*` stable throughout; response 0x0000_ABCD arrives 1 cycle after `mem_ready`.
- `resp_ready` low 4 cycles after a load -> `resp_*` stable; `req_ready`=0 until the cycle after the handshake; back-to-back requests complete in order.
- Reset pulse while in BUS -> `mem_valid` falls without waiting for a clock edge; no response appears; the next request completes normally.
